intirvx_wb_arbiter: RTL
=======================

// Module: intirvx_wb_arbiter
// PURPOSE
//  Arbitrates the single register-file write-back port among the ALU, MEM and CSR result producers.
//  Sits between the execute units and the register manager's write-back bus.
//  Round-robin (or fixed-priority) grant; one registered output slot with valid/ready back-pressure.
//  Exceptions reported by MEM/CSR are forwarded, with the register write suppressed.
// PARAMETERS
//  XLEN    32  data width of results
//  RR_EN   1   1: round-robin arbitration; 0: fixed priority MEM > CSR > ALU
// PORTS
//  clk            in   1     core clock; all state updates on rising edge
//  rst            in   1     reset, synchronous, active-high
//  alu_res        in   XLEN  ALU result
//  alu_rd         in   5     ALU destination register
//  alu_valid      in   1     ALU result pending
//  alu_ready      out  1     ALU result accepted this cycle
//  mem_res        in   XLEN  load result
//  mem_rd         in   5     load destination register
//  mem_exception  in   1     load/store fault
//  mem_valid      in   1     MEM result pending
//  mem_ready      out  1     MEM result accepted this cycle
//  csr_res        in   XLEN  CSR read value
//  csr_rd         in   5     CSR destination register
//  csr_exception  in   1     CSR access fault / trap
//  csr_valid      in   1     CSR result pending
//  csr_ready      out  1     CSR result accepted this cycle
//  wb_data        out  XLEN  write-back data
//  wb_rd          out  5     write-back register index
//  wb_we          out  1     register write enable (qualified by wb_valid)
//  wb_exception   out  1     granted source raised an exception
//  wb_src         out  2     granted source: 0 ALU, 1 MEM, 2 CSR
//  wb_valid       out  1     output slot holds a result
//  wb_ready       in   1     consumer accepts the output slot
// BEHAVIOUR
//  - Reset: wb_valid=0, wb_we=0, wb_exception=0, wb_src=0, wb_rd=0, wb_data=0, rr_ptr=2 (ALU next).
//    Reset asserted mid-transfer drops the held slot; no *_ready is asserted while rst=1.
//  - Slot free: slot_free = !wb_valid | wb_ready. No grant when !slot_free; all *_ready=0.
//  - Grant (combinational, same cycle): at most one of alu/mem/csr_ready high, only for a valid source.
//    RR_EN=1: search order starts at (rr_ptr+1) mod 3, indices ALU=0, MEM=1, CSR=2.
//    RR_EN=0: MEM, then CSR, then ALU; rr_ptr unused.
//  - On grant (x_valid & x_ready), next cycle: wb_valid=1, wb_data/wb_rd/wb_src loaded from the winner;
//    wb_exception = winner exception (0 for ALU); wb_we = (rd != 0) & !exception; rr_ptr = winner.
//  - Latency: accepted result appears on wb_* exactly 1 cycle after its handshake.
//  - Hold: while wb_valid & !wb_ready, all wb_* outputs are stable and no source is granted.
//  - Back-to-back: wb_valid & wb_ready with a grant in the same cycle reloads the slot; 1 result/cycle.
//  - Consume without new grant: wb_valid falls to 0 next cycle; wb_we also cleared.
//  - Rejected requesters keep valid and payload stable (producer contract); the arbiter keeps no copy.
//  - rd=0 with no exception: wb_valid=1, wb_we=0 (retires, no register write).
//  - Exception: wb_we=0 whatever rd is; the data field is passed through unchanged.
//  - Fairness: RR_EN=1 and all three continuously valid with wb_ready=1 -> grants cycle ALU, MEM, CSR.
// TESTING
//  1 Reset, then alu_valid=1, rd=5, res=0x1234, wb_ready=1 -> alu_ready same cycle; next cycle
//    wb_valid=1, wb_rd=5, wb_data=0x1234, wb_we=1, wb_src=0.
//  2 All three valid for 6 cycles, wb_ready=1, RR_EN=1 -> wb_src sequence 0,1,2,0,1,2; no idle cycles.
//  3 Same stimulus, RR_EN=0 -> MEM granted every cycle; ALU/CSR ready stay 0 while mem_valid=1.
//  4 Slot full, wb_ready=0 for 3 cycles, alu_valid=1 -> wb_* frozen, alu_ready=0; wb_ready=1 ->
//    grant that cycle, new result the next cycle.
//  5 mem_valid=1, mem_exception=1, rd=7; then csr_valid=1, rd=0, no exception ->
//    wb_exception=1, wb_we=0; then wb_valid=1, wb_we=0.
//  6 rst=1 while wb_valid=1 and alu_valid=1 -> next cycle wb_valid=0, alu_ready=0 during rst;
//    after release, first grant goes to ALU.

Source files
------------

// File: rtl/intirvx_wb_arbiter.sv
// -----------------------------------------------------------------------------
// intirvx_wb_arbiter
//
// Purpose
//   Arbitrates the single register-file write-back port among three result
//   producers: ALU, MEM (loads) and CSR. The winner is chosen combinationally
//   in the same cycle its request is seen. The winner's payload is captured
//   into one registered output slot, which the register manager drains with a
//   valid/ready handshake. Exceptions raised by MEM or CSR travel with the
//   result, and they suppress the register write.
//
// Handshake semantics (both sides)
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. A producer that is not granted must hold valid and payload stable;
//   the arbiter keeps no copy of a rejected request. ready is a pure function
//   of the current valids, the slot state, wb_ready and rst. It never depends
//   on a registered request.
//
// Parameters
//   XLEN   data width of results
//   RR_EN  1: round-robin arbitration; 0: fixed priority MEM > CSR > ALU
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   alu_res/alu_rd/alu_valid      ALU result request        -> alu_ready
//   mem_res/mem_rd/mem_exception  MEM result request
//     mem_valid                                             -> mem_ready
//   csr_res/csr_rd/csr_exception  CSR result request
//     csr_valid                                             -> csr_ready
//   wb_data/wb_rd/wb_we           write-back payload (wb_we qualified by wb_valid)
//   wb_exception/wb_src           fault flag and granted source (0 ALU, 1 MEM, 2 CSR)
//   wb_valid/wb_ready             output slot handshake
// -----------------------------------------------------------------------------
module intirvx_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int RR_EN = 1
) (
  input  logic            clk,
  input  logic            rst,

  input  logic [XLEN-1:0] alu_res,
  input  logic [4:0]      alu_rd,
  input  logic            alu_valid,
  output logic            alu_ready,

  input  logic [XLEN-1:0] mem_res,
  input  logic [4:0]      mem_rd,
  input  logic            mem_exception,
  input  logic            mem_valid,
  output logic            mem_ready,

  input  logic [XLEN-1:0] csr_res,
  input  logic [4:0]      csr_rd,
  input  logic            csr_exception,
  input  logic            csr_valid,
  output logic            csr_ready,

  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic            wb_exception,
  output logic [1:0]      wb_src,
  output logic            wb_valid,
  input  logic            wb_ready
);

  // Source indices, shared by the round-robin pointer and wb_src.
  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_CSR = 2'd2;

  // ---------------------------------------------------------------------------
  // Output slot and round-robin pointer
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] r_wb_data;
  logic [4:0]      r_wb_rd;
  logic            r_wb_we;
  logic            r_wb_exception;
  logic [1:0]      r_wb_src;
  logic            r_wb_valid;
  // Index of the last granted source. The search starts at the following
  // index. Reset to CSR so that ALU is searched first.
  logic [1:0]      r_rr_ptr;

  // ---------------------------------------------------------------------------
  // Combinational grant
  // ---------------------------------------------------------------------------
  logic            w_slot_free;
  logic [3:0]      w_req;        // bit 3 is a constant 0 so any 2-bit index stays in range
  logic [1:0]      w_ord0;
  logic [1:0]      w_ord1;
  logic [1:0]      w_ord2;
  logic            w_grant_any;
  logic [1:0]      w_grant_idx;

  logic [XLEN-1:0] w_sel_data;
  logic [4:0]      w_sel_rd;
  logic            w_sel_exc;
  logic            w_sel_we;

  // Modulo-3 increment over the source indices.
  function automatic logic [1:0] inc3(input logic [1:0] idx);
    inc3 = (idx == SRC_CSR) ? SRC_ALU : idx + 2'd1;
  endfunction

  // The slot can take a new result if it is empty or is being drained this
  // cycle. When it is being drained, one result per cycle flows through.
  assign w_slot_free = !r_wb_valid || wb_ready;
  assign w_req       = {1'b0, csr_valid, mem_valid, alu_valid};

  // Search order for round-robin mode.
  assign w_ord0 = inc3(r_rr_ptr);
  assign w_ord1 = inc3(w_ord0);
  assign w_ord2 = inc3(w_ord1);

  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = SRC_ALU;
    // Reset and a held slot both block every grant. Then no ready is seen.
    if (!rst && w_slot_free) begin
      if (RR_EN != 0) begin
        if (w_req[w_ord0]) begin
          w_grant_any = 1'b1;
          w_grant_idx = w_ord0;
        end else if (w_req[w_ord1]) begin
          w_grant_any = 1'b1;
          w_grant_idx = w_ord1;
        end else if (w_req[w_ord2]) begin
          w_grant_any = 1'b1;
          w_grant_idx = w_ord2;
        end
      end else begin
        // Fixed priority: loads first so a memory stall drains soonest.
        if (mem_valid) begin
          w_grant_any = 1'b1;
          w_grant_idx = SRC_MEM;
        end else if (csr_valid) begin
          w_grant_any = 1'b1;
          w_grant_idx = SRC_CSR;
        end else if (alu_valid) begin
          w_grant_any = 1'b1;
          w_grant_idx = SRC_ALU;
        end
      end
    end
  end

  assign alu_ready = w_grant_any && (w_grant_idx == SRC_ALU);
  assign mem_ready = w_grant_any && (w_grant_idx == SRC_MEM);
  assign csr_ready = w_grant_any && (w_grant_idx == SRC_CSR);

  // Payload of the winner. The ALU has no exception input.
  always_comb begin
    w_sel_data = alu_res;
    w_sel_rd   = alu_rd;
    w_sel_exc  = 1'b0;
    case (w_grant_idx)
      SRC_MEM: begin
        w_sel_data = mem_res;
        w_sel_rd   = mem_rd;
        w_sel_exc  = mem_exception;
      end
      SRC_CSR: begin
        w_sel_data = csr_res;
        w_sel_rd   = csr_rd;
        w_sel_exc  = csr_exception;
      end
      default: begin
        w_sel_data = alu_res;
        w_sel_rd   = alu_rd;
        w_sel_exc  = 1'b0;
      end
    endcase
  end

  // x0 is never written. A faulting result retires without touching the
  // register file, but its data is still passed through for the trap path.
  assign w_sel_we = (w_sel_rd != 5'd0) && !w_sel_exc;

  // ---------------------------------------------------------------------------
  // Slot register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_we        <= 1'b0;
      r_wb_exception <= 1'b0;
      r_wb_src       <= SRC_ALU;
      r_wb_rd        <= 5'd0;
      r_wb_data      <= '0;
      r_rr_ptr       <= SRC_CSR;
    end else if (w_slot_free) begin
      if (w_grant_any) begin
        r_wb_valid     <= 1'b1;
        r_wb_data      <= w_sel_data;
        r_wb_rd        <= w_sel_rd;
        r_wb_src       <= w_grant_idx;
        r_wb_exception <= w_sel_exc;
        r_wb_we        <= w_sel_we;
        r_rr_ptr       <= w_grant_idx;
      end else begin
        // The slot was drained, or was already empty, and nothing new came in.
        // Clear wb_we as well, so that a stale write enable never lingers.
        r_wb_valid <= 1'b0;
        r_wb_we    <= 1'b0;
      end
    end
    // When the slot is held (wb_valid && !wb_ready), every output keeps its value.
  end

  assign wb_data      = r_wb_data;
  assign wb_rd        = r_wb_rd;
  assign wb_we        = r_wb_we;
  assign wb_exception = r_wb_exception;
  assign wb_src       = r_wb_src;
  assign wb_valid     = r_wb_valid;

endmodule
